// File: rtl/depth_test_stage.sv
// depth_test_stage: per-pixel depth test with write forwarding and a drain-then-sweep depth clear
module depth_test_stage #(
   parameter int SIZE    = 64,
   parameter int WIDTH   = 9,
   parameter int COLORW  = 10,
   localparam int ADDRW  = $clog2(SIZE*SIZE)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clear_start,
   input  logic                      valid_in,
   input  logic [ADDRW+COLORW+WIDTH-1:0] pixel_in,
   output logic                      ready_out,
   output logic                      clear_busy,
   output logic                      valid_out,
   output logic [ADDRW-1:0]          pixel_addr,
   output logic [COLORW-1:0]         pixel_out
);
   typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;
   state_t              state_q, state_d;
   logic [ADDRW:0]      clr_q, clr_d;
   logic                s1_v_q;
   logic [ADDRW-1:0]    s1_addr_q;
   logic [COLORW-1:0]   s1_col_q;
   logic [WIDTH-1:0]    s1_dep_q;
   logic [WIDTH-1:0]    rd_q;
   logic                fwd_v_q;
   logic [ADDRW-1:0]    fwd_addr_q;
   logic [WIDTH-1:0]    fwd_dep_q;
   logic                vout_q;
   logic [ADDRW-1:0]    addr_q;
   logic [COLORW-1:0]   col_q;
   logic [WIDTH-1:0]    mem [SIZE*SIZE];
   logic                accept, pass, clearing, last;
   logic [WIDTH-1:0]    stored;
   logic [ADDRW-1:0]    in_addr;
   assign in_addr    = pixel_in[ADDRW+COLORW+WIDTH-1 -: ADDRW];
   assign ready_out  = state_q == RUN;
   assign clear_busy = state_q != RUN;
   assign valid_out  = vout_q;
   assign pixel_addr = addr_q;
   assign pixel_out  = col_q;
   assign accept     = valid_in && ready_out;
   assign clearing   = state_q == CLEAR;
   assign last       = clr_q == (ADDRW+1)'(SIZE*SIZE-1);
   // the RAM read issued alongside the previous pixel's write is stale, so prefer the last write
   assign stored     = (fwd_v_q && fwd_addr_q == s1_addr_q) ? fwd_dep_q : rd_q;
   assign pass       = s1_v_q && (s1_dep_q < stored);
   // drain ends once nothing will remain in S1 or the output register after this edge
   always_comb begin
      state_d = state_q == RUN   ? (clear_start ? DRAIN : RUN) :
                state_q == DRAIN ? (pass ? DRAIN : CLEAR) :
                (last && !clear_start) ? RUN : CLEAR;
      clr_d   = (clearing && !clear_start && !last) ? clr_q + 1'b1 : '0;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= CLEAR;
         clr_q      <= '0;
         s1_v_q     <= 1'b0;
         s1_addr_q  <= '0;
         s1_col_q   <= '0;
         s1_dep_q   <= '0;
         fwd_v_q    <= 1'b0;
         fwd_addr_q <= '0;
         fwd_dep_q  <= '0;
         vout_q     <= 1'b0;
         addr_q     <= '0;
         col_q      <= '0;
      end else begin
         state_q <= state_d;
         clr_q   <= clr_d;
         s1_v_q  <= accept;
         vout_q  <= pass;
         fwd_v_q <= (clearing && last) ? 1'b0 : (fwd_v_q || pass);
         if (accept) {s1_addr_q, s1_col_q, s1_dep_q} <= pixel_in;
         if (pass) begin
            addr_q     <= s1_addr_q;
            col_q      <= s1_col_q;
            fwd_addr_q <= s1_addr_q;
            fwd_dep_q  <= s1_dep_q;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (clearing || pass) mem[clearing ? clr_q[ADDRW-1:0] : s1_addr_q] <= clearing ? {WIDTH{1'b1}} : s1_dep_q;
      rd_q <= mem[in_addr];
   end
endmodule

// File: tb/tb_depth_test_stage.sv
// tb_depth_test_stage: random and directed pixels against a per-address nearest-depth model
module tb_depth_test_stage;
   localparam int AW = 12, CW = 10, DW = 9, PW = AW + CW + DW;
   logic          clk = 1'b0, rst = 1'b1, clear_start = 1'b0, valid_in = 1'b0;
   logic [PW-1:0] pixel_in = '0;
   logic          ready_out, clear_busy, valid_out;
   logic [AW-1:0] pixel_addr;
   logic [CW-1:0] pixel_out;
   typedef struct {int due; logic [AW-1:0] addr; logic [CW-1:0] col;} exp_t;
   exp_t          q[$];
   logic [DW-1:0] mdl [1<<AW];
   int            t = 0, n_chk = 0, n_fail = 0;

   depth_test_stage dut (
      .clk(clk), .rst(rst), .clear_start(clear_start), .valid_in(valid_in), .pixel_in(pixel_in),
      .ready_out(ready_out), .clear_busy(clear_busy), .valid_out(valid_out),
      .pixel_addr(pixel_addr), .pixel_out(pixel_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
      end
   endtask

   function automatic logic [PW-1:0] pix(input int a, input int c, input int d);
      return {AW'(a), CW'(c), DW'(d)};
   endfunction

   function automatic logic [PW-1:0] rnd_pix();
      return pix(int'($urandom_range(0, 63)), int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)));
   endfunction

   task automatic model_clear();
      foreach (mdl[i]) mdl[i] = '1;
   endtask

   // mode 1: block must be ready, 0: must be busy, 2: no expectation on ready
   task automatic step(input logic v, input logic [PW-1:0] p, input logic clr, input int mode);
      logic [AW-1:0] a;
      a = p[PW-1 -: AW];
      valid_in = v; pixel_in = p; clear_start = clr;
      if (mode == 1) begin chk("ready", ready_out, 1); chk("busy", clear_busy, 0); end
      if (mode == 0) begin chk("ready_low", ready_out, 0); chk("busy_high", clear_busy, 1); end
      if (mode == 1 && v && p[DW-1:0] < mdl[a]) begin
         mdl[a] = p[DW-1:0];
         q.push_back('{t + 2, a, p[DW +: CW]});
      end
      if (clr) model_clear();
      @(posedge clk); #1; t++;
      if (q.size() > 0 && q[0].due == t) begin
         chk("valid_out", valid_out, 1);
         chk("pixel_addr", pixel_addr, q[0].addr);
         chk("pixel_out", pixel_out, q[0].col);
         void'(q.pop_front());
      end else chk("valid_out", valid_out, 0);
      valid_in = 0; clear_start = 0;
   endtask

   task automatic wait_ready(input int lo, input int hi, input string tag);
      int n = 0;
      while (ready_out !== 1'b1 && n <= hi) begin
         chk("busy_in_clear", clear_busy, 1);
         step(1'($urandom_range(0, 1)), rnd_pix(), 1'b0, 2);
         n++;
      end
      if (lo == hi) chk(tag, n, lo);
      else chk(tag, n >= lo && n <= hi, 1);
   endtask

   task automatic do_reset();
      rst = 1'b1; valid_in = 0; clear_start = 0;
      #2;
      chk("rst_valid_out", valid_out, 0);
      chk("rst_pixel_addr", pixel_addr, 0);
      chk("rst_pixel_out", pixel_out, 0);
      chk("rst_ready", ready_out, 0);
      chk("rst_busy", clear_busy, 1);
      @(posedge clk); #1; t++;
      rst = 1'b0;
      q.delete();
      model_clear();
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      do_reset();
      wait_ready(4096, 4096, "init_clear_len");
      step(1, pix(5, 'h2AA, 100), 0, 1);
      repeat (2) step(0, '0, 0, 1);
      step(1, pix(7, 1, 200), 0, 1);
      step(1, pix(7, 2, 100), 0, 1);
      step(1, pix(7, 3, 150), 0, 1);
      repeat (2) step(0, '0, 0, 1);
      step(1, pix(9, 4, 50), 0, 1);
      repeat (2) step(0, '0, 0, 1);
      step(1, pix(9, 5, 50), 0, 1);
      step(1, pix(9, 6, 49), 0, 1);
      repeat (2) step(0, '0, 0, 1);
      for (int i = 0; i < 2000; i++) step($urandom_range(0, 3) != 0, rnd_pix(), 0, 1);
      step(1, pix(3, 'h3C, 0), 1, 1);
      wait_ready(4097, 4098, "drain_clear_len");
      step(1, pix(7, 'h155, 300), 0, 1);
      repeat (2) step(0, '0, 0, 1);
      step(1, pix(20, 7, 'h1FF), 0, 1);
      repeat (2) step(0, '0, 0, 1);
      step(0, '0, 1, 1);
      for (int i = 0; i < 500; i++) step(1, rnd_pix(), 0, 0);
      step(0, '0, 1, 0);
      wait_ready(4096, 4096, "restart_clear_len");
      for (int i = 0; i < 300; i++) step($urandom_range(0, 1) != 0, rnd_pix(), 0, 1);
      repeat (2) step(0, '0, 0, 1);
      do_reset();
      for (int i = 0; i < 2000; i++) step(1, rnd_pix(), 0, 0);
      do_reset();
      wait_ready(4096, 4096, "reset_mid_clear_len");
      for (int i = 0; i < 300; i++) step($urandom_range(0, 3) != 0, rnd_pix(), 0, 1);
      repeat (3) step(0, '0, 0, 1);
      chk("queue_empty", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
